lf_cap_sched: RTL and testbench
===============================

# lf_cap_sched

Loop-filter capacitor drive scheduler for the CDR. It shares the single capacitor drive channel between NREQ charge requesters, such as the phase-detector charge pump and the calibration engine, using round-robin arbitration. It also generates the integration update strobe (upd) that the capacitor model's voltage update is aligned to, and sequences initial-condition preloads. It tracks the net charge delivered to the capacitor as a saturating signed accumulator.

## Interface
- NREQ, 2: number of requesters (2..4)
- IW, 8: signed current-code width
- DW, 8: unsigned duration width, in upd ticks
- AW, 16: signed charge accumulator width
- TDIV, 4: ck cycles per upd tick (≥2)
- SETTLE, 2: settle cycles after each drive (≥1)

Ports:
- ck  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- req_icode  in  NREQ*IW  signed current code; slice i belongs to requester i
- req_dur  in  NREQ*DW  drive duration in upd ticks; slice i belongs to requester i
- init  in  1  one-cycle preload request
- init_code  in  IW  signed preload code, sampled with init
- gnt  out  NREQ  one-hot grant
- done  out  NREQ  one-cycle completion pulse to the granted requester
- upd  out  1  integration tick strobe
- drv_en  out  1  capacitor current drive enable
- drv_icode  out  IW  signed drive code; 0 whenever drv_en=0 and drv_preload=0
- drv_preload  out  1  capacitor initial-condition load
- charge_acc  out  AW  signed net charge, in code·ticks
- acc_sat  out  1  sticky saturation flag
- busy  out  1  state ≠ IDLE

## Operation
- Tick divider:
  - Free-running counter tcnt counts 0..TDIV-1 and wraps.
  - upd=1 when tcnt==TDIV-1.
  - The divider is independent of the FSM.
- FSM states: IDLE, PRELOAD, DRIVE, SETTLE.
- IDLE:
  - If init_pend=1, go to PRELOAD. Preload has priority over any req.
  - Otherwise, if any req bit is set, pick the first set bit searching from rr_ptr upward with wrap-around.
  - On a pick: latch that requester's icode and dur, assert gnt[i], set rr_ptr=(i+1) mod NREQ.
  - Go to DRIVE, or straight to SETTLE if dur==0.
- DRIVE:
  - drv_en=1 and drv_icode=latched code.
  - On each upd: charge_acc += sign-extended icode (saturating), then rem -= 1.
  - When rem reaches 0, go to SETTLE on the next cycle.
  - The first counted tick is the first upd occurring while in DRIVE.
- SETTLE:
  - drv_en=0, gnt held.
  - Lasts SETTLE cycles. done[i]=1 in the last one, then go to IDLE with gnt=0.
- PRELOAD:
  - drv_preload=1, drv_icode=latched init code.
  - On entry, charge_acc = sign-extended init code and acc_sat is cleared.
  - Held until the next upd inclusive, then go to IDLE.
  - init_pend clears on entry.
- init handling:
  - An init pulse in any state sets init_pend and latches init_code.
  - A later init pulse before service overwrites the latched code.
  - An in-progress grant is never preempted. The preload is served right after SETTLE completes.
- Saturation:
  - charge_acc clamps at +2^(AW-1)-1 and -2^(AW-1).
  - Any clamp event sets acc_sat.
  - acc_sat clears only on reset or PRELOAD entry.
- Request protocol:
  - A requester holds req until done.
  - Dropping req early does not abort the grant.
  - req still high in IDLE after done counts as a new request at lower round-robin priority.

## Timing
- Reset values:
  - FSM in IDLE.
  - tcnt=0, rr_ptr=0, init_pend=0, rem=0.
  - All outputs 0: gnt, done, upd, drv_en, drv_icode, drv_preload, charge_acc, acc_sat, busy.
- Reset asserted mid-operation: outputs go to reset values immediately and asynchronously. Pending init and the latched request are discarded.
- Grant latency: req sampled high in IDLE at edge n gives gnt and drv_en high after edge n; busy rises on the same edge.
- Drive length: exactly dur upd ticks counted.
- Drive-to-release sequence:
  - drv_en falls on the edge after the last counted upd.
  - SETTLE cycles follow.
  - done is high for 1 cycle.
  - gnt falls with done's falling edge.
- Minimum back-to-back gap between two grants: 1 IDLE cycle.
- Simultaneous init and req in IDLE: PRELOAD wins; the req is served on the next IDLE.
- charge_acc updates on the same edge that upd is sampled high.

## Test plan
- Reset mid-DRIVE: assert rst_n=0 → all outputs 0 within the same cycle; after release, the first grant goes to requester 0.
- Single request with TDIV=4, req[0]=1, icode=+5, dur=3:
  - gnt=01 and drv_en for 3 upd ticks.
  - charge_acc=15.
  - done[0] pulses once, SETTLE=2 cycles after drv_en falls.
- Round robin: req=11 held continuously → grants alternate 01,10,01,10; each has the correct icode (+3 and -2) and charge_acc nets to +2 after two grants with dur=2.
- Preload priority: init with code=-7 pulsed during requester 1's DRIVE → no preemption; PRELOAD runs immediately after done[1] even with req[0] high; then charge_acc=-7 and acc_sat=0.
- Saturation with AW=8: icode=+100, dur=3 → charge_acc=127 and acc_sat=1; a following icode=-27 gives 100 and acc_sat stays 1.
- Zero duration: dur=0 → gnt for SETTLE cycles, drv_en never asserted, charge_acc unchanged, done pulses once.

Source files
------------

// File: rtl/lf_cap_sched_if.sv
// Bus bundle between the loop-filter capacitor drive scheduler and its
// requesters / capacitor model. Clock and reset stay outside the bundle.
interface lf_cap_sched_if #(
  parameter int NREQ = 2,
  parameter int IW   = 8,
  parameter int DW   = 8,
  parameter int AW   = 16
) ();
  logic [NREQ-1:0]    req;
  logic [NREQ*IW-1:0] req_icode;
  logic [NREQ*DW-1:0] req_dur;
  logic               init;
  logic [IW-1:0]      init_code;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               upd;
  logic               drv_en;
  logic [IW-1:0]      drv_icode;
  logic               drv_preload;
  logic [AW-1:0]      charge_acc;
  logic               acc_sat;
  logic               busy;

  // Scheduler side
  modport slave (
    input  req, req_icode, req_dur, init, init_code,
    output gnt, done, upd, drv_en, drv_icode, drv_preload, charge_acc, acc_sat, busy
  );

  // Requester / capacitor-model side
  modport master (
    output req, req_icode, req_dur, init, init_code,
    input  gnt, done, upd, drv_en, drv_icode, drv_preload, charge_acc, acc_sat, busy
  );
endinterface

// File: rtl/lf_cap_sched.sv
// Loop-filter capacitor drive scheduler: round-robin sharing of the single
// capacitor drive channel, integration tick (upd) generation, initial-condition
// preload sequencing and a saturating signed net-charge accumulator.
module lf_cap_sched #(
  parameter int NREQ   = 2,
  parameter int IW     = 8,
  parameter int DW     = 8,
  parameter int AW     = 16,
  parameter int TDIV   = 4,
  parameter int SETTLE = 2
) (
  input  logic          ck,
  input  logic          rst_n,
  lf_cap_sched_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TDIV);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TW-1:0] TMAX    = TW'(TDIV - 1);
  localparam logic [SW-1:0] SMAX    = SW'(SETTLE - 1);
  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_DRIVE   = 2'd2,
    ST_SETTLE  = 2'd3
  } state_t;

  // Sign-extend a current code to accumulator width
  function automatic logic [AW-1:0] sext_code(input logic [IW-1:0] c);
    return {{(AW-IW){c[IW-1]}}, c};
  endfunction

  // Saturating signed add; result MSB flags a clamp event
  function automatic logic [AW:0] sat_add(input logic [AW-1:0] acc, input logic [IW-1:0] c);
    logic [AW-1:0] e;
    logic [AW:0]   s;
    e = sext_code(c);
    s = {acc[AW-1], acc} + {e[AW-1], e};
    if (s[AW] != s[AW-1]) begin
      return {1'b1, (s[AW] ? ACC_MIN : ACC_MAX)};
    end else begin
      return {1'b0, s[AW-1:0]};
    end
  endfunction

  state_t          r_state;
  logic [TW-1:0]   r_tcnt;
  logic            r_upd;
  logic [PW-1:0]   r_rr_ptr;
  logic            r_init_pend;
  logic [IW-1:0]   r_init_code;
  logic [DW-1:0]   r_rem;
  logic [SW-1:0]   r_scnt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_drv_en;
  logic [IW-1:0]   r_drv_icode;
  logic            r_drv_preload;
  logic [AW-1:0]   r_acc;
  logic            r_sat;
  logic            r_busy;

  logic [TW-1:0]   w_tcnt_nxt;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_pick;
  logic            w_any;
  logic [NREQ-1:0] w_onehot;
  logic [IW-1:0]   w_icode;
  logic [DW-1:0]   w_dur;
  logic [PW-1:0]   w_ptr_nxt;
  logic [IW-1:0]   w_pre_code;
  logic [AW:0]     w_sat_res;

  assign w_tcnt_nxt = (r_tcnt == TMAX) ? '0 : r_tcnt + TW'(1);
  assign w_ptr_nxt  = (w_pick == PW'(NREQ - 1)) ? '0 : w_pick + PW'(1);
  // A pulse arriving in the same cycle as the preload launch is the freshest code
  assign w_pre_code = bus.init ? bus.init_code : r_init_code;
  assign w_sat_res  = sat_add(r_acc, r_drv_icode);

  // Round-robin pick from rr_ptr upward; the lowest offset with a request wins
  always_comb begin
    w_any    = 1'b0;
    w_pick   = '0;
    w_idx    = '0;
    w_onehot = '0;
    w_icode  = '0;
    w_dur    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_rr_ptr) + k) % NREQ);
      if (bus.req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end else begin
        w_pick = w_pick;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == PW'(i)) begin
        w_onehot[i] = 1'b1;
        w_icode     = bus.req_icode[i*IW +: IW];
        w_dur       = bus.req_dur[i*DW +: DW];
      end else begin
        w_onehot[i] = 1'b0;
      end
    end
  end

  // Free-running tick divider; upd is registered so it is high while tcnt==TDIV-1
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_upd  <= 1'b0;
    end else begin
      r_tcnt <= w_tcnt_nxt;
      r_upd  <= (w_tcnt_nxt == TMAX);
    end
  end

  // Scheduler FSM with init capture, accumulator and all registered outputs
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_init_pend   <= 1'b0;
      r_init_code   <= '0;
      r_rem         <= '0;
      r_scnt        <= '0;
      r_gnt         <= '0;
      r_done        <= '0;
      r_drv_en      <= 1'b0;
      r_drv_icode   <= '0;
      r_drv_preload <= 1'b0;
      r_acc         <= '0;
      r_sat         <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_done <= '0;
      if (bus.init) begin
        r_init_pend <= 1'b1;
        r_init_code <= bus.init_code;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.init || r_init_pend) begin
            r_state       <= ST_PRELOAD;
            r_init_pend   <= 1'b0;
            r_drv_preload <= 1'b1;
            r_drv_icode   <= w_pre_code;
            r_acc         <= sext_code(w_pre_code);
            r_sat         <= 1'b0;
            r_busy        <= 1'b1;
          end else if (w_any) begin
            r_gnt    <= w_onehot;
            r_rr_ptr <= w_ptr_nxt;
            r_rem    <= w_dur;
            r_busy   <= 1'b1;
            if (w_dur == '0) begin
              // Zero-length drive: channel is held for the settle window only
              r_state <= ST_SETTLE;
              r_scnt  <= SMAX;
              r_done  <= (SETTLE == 1) ? w_onehot : '0;
            end else begin
              r_state     <= ST_DRIVE;
              r_drv_en    <= 1'b1;
              r_drv_icode <= w_icode;
            end
          end
        end
        ST_PRELOAD: begin
          if (r_upd) begin
            r_state       <= ST_IDLE;
            r_drv_preload <= 1'b0;
            r_drv_icode   <= '0;
            r_busy        <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (r_upd) begin
            r_acc <= w_sat_res[AW-1:0];
            if (w_sat_res[AW]) begin
              r_sat <= 1'b1;
            end
            r_rem <= r_rem - DW'(1);
            if (r_rem == DW'(1)) begin
              r_state     <= ST_SETTLE;
              r_drv_en    <= 1'b0;
              r_drv_icode <= '0;
              r_scnt      <= SMAX;
              r_done      <= (SETTLE == 1) ? r_gnt : '0;
            end
          end
        end
        ST_SETTLE: begin
          if (r_scnt == '0) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_scnt <= r_scnt - SW'(1);
            if (r_scnt == SW'(1)) begin
              r_done <= r_gnt;
            end
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_gnt         <= '0;
          r_drv_en      <= 1'b0;
          r_drv_icode   <= '0;
          r_drv_preload <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.done        = r_done;
  assign bus.upd         = r_upd;
  assign bus.drv_en      = r_drv_en;
  assign bus.drv_icode   = r_drv_icode;
  assign bus.drv_preload = r_drv_preload;
  assign bus.charge_acc  = r_acc;
  assign bus.acc_sat     = r_sat;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_lf_cap_sched.sv
// Scoreboard bench for lf_cap_sched (NREQ=2, IW=8, DW=8, AW=8, TDIV=4, SETTLE=2).
// Stimulus pushes hand-computed expected grant/preload outcomes; a monitor pops
// them when done pulses or when a preload reaches its closing upd tick.
module tb_lf_cap_sched;

  localparam int SETTLE = 2;

  typedef struct {
    bit pre;
    int idx;
    int icode;
    int dur;
    int acc;
    bit sat;
  } exp_t;

  logic ck;
  logic rst_n;
  exp_t sb[$];
  int   n_tests;
  int   n_fail;
  int   m_ticks;
  int   m_settle;
  int   m_icode;

  lf_cap_sched_if #(.NREQ(2), .IW(8), .DW(8), .AW(8)) bus ();

  lf_cap_sched #(
    .NREQ(2), .IW(8), .DW(8), .AW(8), .TDIV(4), .SETTLE(SETTLE)
  ) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input bit pre, input int idx, input int icode, input int dur,
                      input int acc, input bit sat);
    exp_t e;
    e.pre = pre; e.idx = idx; e.icode = icode; e.dur = dur; e.acc = acc; e.sat = sat;
    sb.push_back(e);
  endtask

  task automatic set_req(input int idx, input int icode, input int dur);
    logic [7:0] c;
    logic [7:0] d;
    c = 8'(icode);
    d = 8'(dur);
    if (idx == 0) begin
      bus.req_icode[7:0] = c;
      bus.req_dur[7:0]   = d;
      bus.req[0]         = 1'b1;
    end else begin
      bus.req_icode[15:8] = c;
      bus.req_dur[15:8]   = d;
      bus.req[1]          = 1'b1;
    end
  endtask

  task automatic wait_done(input logic [1:0] mask);
    int c;
    c = 0;
    do begin
      @(negedge ck);
      c++;
    end while (((bus.done & mask) == 2'b00) && c < 300);
    check("wait_done", (c < 300) ? 1 : 0, 1);
  endtask

  task automatic wait_drv();
    int c;
    c = 0;
    do begin
      @(negedge ck);
      c++;
    end while (bus.drv_en !== 1'b1 && c < 100);
    check("wait_drv_en", (c < 100) ? 1 : 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},         int'(bus.gnt), 0);
    check({tag, "_done"},        int'(bus.done), 0);
    check({tag, "_upd"},         int'(bus.upd), 0);
    check({tag, "_drv_en"},      int'(bus.drv_en), 0);
    check({tag, "_drv_icode"},   int'(bus.drv_icode), 0);
    check({tag, "_drv_preload"}, int'(bus.drv_preload), 0);
    check({tag, "_charge_acc"},  int'(bus.charge_acc), 0);
    check({tag, "_acc_sat"},     int'(bus.acc_sat), 0);
    check({tag, "_busy"},        int'(bus.busy), 0);
  endtask

  // Monitor: tracks the active grant and pops the scoreboard on each completion
  always @(negedge ck) begin
    exp_t e;
    if (!rst_n) begin
      m_ticks  = 0;
      m_settle = 0;
      m_icode  = 0;
    end else begin
      if (bus.drv_en && bus.upd) m_ticks++;
      if (bus.drv_en) m_icode = int'($signed(bus.drv_icode));
      if (bus.gnt != 2'b00 && !bus.drv_en) m_settle++;
      if (!bus.drv_en && !bus.drv_preload) check("icode_idle_zero", int'(bus.drv_icode), 0);
      check("busy", int'(bus.busy), int'((bus.gnt != 2'b00) || bus.drv_preload));
      if (bus.done != 2'b00) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=%b expected none at %0t", bus.done, $time);
        end else begin
          e = sb.pop_front();
          check("done_kind",   int'(e.pre), 0);
          check("done_onehot", int'(bus.done), 1 << e.idx);
          check("gnt_match",   int'(bus.gnt), 1 << e.idx);
          check("drive_ticks", m_ticks, e.dur);
          check("settle_len",  m_settle, SETTLE);
          if (e.dur > 0) check("drive_icode", m_icode, e.icode);
          check("charge_acc",  int'($signed(bus.charge_acc)), e.acc);
          check("acc_sat",     int'(bus.acc_sat), int'(e.sat));
        end
        m_ticks  = 0;
        m_settle = 0;
        m_icode  = 0;
      end
      if (bus.drv_preload && bus.upd) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_preload: got preload expected none at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("pre_kind",       int'(e.pre), 1);
          check("pre_gnt",        int'(bus.gnt), 0);
          check("pre_icode",      int'($signed(bus.drv_icode)), e.icode);
          check("pre_charge_acc", int'($signed(bus.charge_acc)), e.acc);
          check("pre_acc_sat",    int'(bus.acc_sat), int'(e.sat));
        end
      end
    end
  end

  initial begin
    int c;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.req = 2'b00;
    bus.req_icode = 16'h0000;
    bus.req_dur = 16'h0000;
    bus.init = 1'b0;
    bus.init_code = 8'h00;
    repeat (3) @(negedge ck);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge ck);

    // Single request: +5 for 3 ticks -> 15
    push(1'b0, 0, 5, 3, 15, 1'b0);
    set_req(0, 5, 3);
    wait_done(2'b01);
    bus.req[0] = 1'b0;
    repeat (2) @(negedge ck);

    // Zero duration on requester 1: accumulator untouched
    push(1'b0, 1, 9, 0, 15, 1'b0);
    set_req(1, 9, 0);
    wait_done(2'b10);
    bus.req[1] = 1'b0;
    repeat (2) @(negedge ck);

    // Round robin, both held: 15 -> 21 -> 17 -> 23 -> 19
    push(1'b0, 0, 3, 2, 21, 1'b0);
    push(1'b0, 1, -2, 2, 17, 1'b0);
    push(1'b0, 0, 3, 2, 23, 1'b0);
    push(1'b0, 1, -2, 2, 19, 1'b0);
    set_req(0, 3, 2);
    set_req(1, -2, 2);
    wait_done(2'b01);
    wait_done(2'b10);
    wait_done(2'b01);
    bus.req[0] = 1'b0;
    wait_done(2'b10);
    bus.req[1] = 1'b0;
    repeat (2) @(negedge ck);

    // Saturation: 19+100 -> 119, 127 (clamp), 127; then -27 -> 100 with sat sticky
    push(1'b0, 0, 100, 3, 127, 1'b1);
    set_req(0, 100, 3);
    wait_done(2'b01);
    bus.req[0] = 1'b0;
    repeat (2) @(negedge ck);
    push(1'b0, 1, -27, 1, 100, 1'b1);
    set_req(1, -27, 1);
    wait_done(2'b10);
    bus.req[1] = 1'b0;
    repeat (2) @(negedge ck);

    // Preload during requester 1 drive, with requester 0 waiting
    push(1'b0, 1, 4, 3, 112, 1'b1);
    push(1'b1, 0, -7, 0, -7, 1'b0);
    push(1'b0, 0, 1, 1, -6, 1'b0);
    set_req(1, 4, 3);
    wait_drv();
    bus.init = 1'b1;
    bus.init_code = 8'hF9;
    set_req(0, 1, 1);
    @(negedge ck);
    bus.init = 1'b0;
    wait_done(2'b10);
    bus.req[1] = 1'b0;
    wait_done(2'b01);
    bus.req[0] = 1'b0;
    repeat (2) @(negedge ck);

    // Simultaneous init and req in IDLE: preload 3 first, then +2 -> 5
    push(1'b1, 0, 3, 0, 3, 1'b0);
    push(1'b0, 0, 2, 1, 5, 1'b0);
    set_req(0, 2, 1);
    bus.init = 1'b1;
    bus.init_code = 8'h03;
    @(negedge ck);
    bus.init = 1'b0;
    wait_done(2'b01);
    bus.req[0] = 1'b0;
    repeat (2) @(negedge ck);
    check("sb_empty_before_reset", sb.size(), 0);

    // Reset mid-drive (rr_ptr is 1 here, so requester 1 is granted)
    set_req(1, 6, 5);
    wait_drv();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    set_req(0, 7, 1);
    set_req(1, -1, 1);
    push(1'b0, 0, 7, 1, 7, 1'b0);
    push(1'b0, 1, -1, 1, 6, 1'b0);
    @(negedge ck);
    rst_n = 1'b1;
    wait_done(2'b01);
    bus.req[0] = 1'b0;
    wait_done(2'b10);
    bus.req[1] = 1'b0;

    c = 0;
    while (sb.size() != 0 && c < 500) begin
      @(negedge ck);
      c++;
    end
    check("sb_drain", sb.size(), 0);
    repeat (4) @(negedge ck);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
